// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

   typedef enum logic [1:0] {
      StPllRst   = 2'd0,
      StWaitLock = 2'd1,
      StStable   = 2'd2,
      StRun      = 2'd3
   } state_e;

   // Timer must hold the largest of the three window lengths minus one.
   function automatic int timer_width(input int unsigned a, input int unsigned b,
                                      input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// Multi-flop bit synchroniser with asynchronous clear.
module pll_lock_supervisor_sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_sync <= '0;
      else         r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Turns the asynchronous PLL lock indication into a qualified system reset,
// retrying the PLL with a reset pulse when lock never arrives.
module pll_lock_supervisor
   import pll_lock_supervisor_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter int unsigned PLLRST_CYCLES  = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_pll_locked,
   output logic             o_pll_rst,
   output logic             o_sys_rst,
   output logic             o_ready,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_lock_loss_cnt,
   output logic [CNT_W-1:0] o_retry_cnt
);

   localparam int TW = timer_width(STABLE_CYCLES, TIMEOUT_CYCLES, PLLRST_CYCLES);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] PLLRST_LAST  = TW'(PLLRST_CYCLES - 1);

   logic             w_locked_s;
   state_e           r_state;
   logic [TW-1:0]    r_timer;
   logic             r_pll_rst;
   logic             r_sys_rst;
   logic             r_ready;
   logic [CNT_W-1:0] r_lock_loss_cnt;
   logic [CNT_W-1:0] r_retry_cnt;

   pll_lock_supervisor_sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync_locked (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_d     (i_pll_locked),
      .o_q     (w_locked_s)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state         <= StPllRst;
         r_timer         <= '0;
         r_pll_rst       <= 1'b1;
         r_sys_rst       <= 1'b1;
         r_ready         <= 1'b0;
         r_lock_loss_cnt <= '0;
         r_retry_cnt     <= '0;
      end else begin
         unique case (r_state)
            StPllRst: begin
               if (r_timer == PLLRST_LAST) begin
                  r_state   <= StWaitLock;
                  r_timer   <= '0;
                  r_pll_rst <= 1'b0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            StWaitLock: begin
               // Lock takes priority over a coincident timeout.
               if (w_locked_s) begin
                  r_state <= StStable;
                  r_timer <= '0;
               end else if (r_timer == TIMEOUT_LAST) begin
                  r_state   <= StPllRst;
                  r_timer   <= '0;
                  r_pll_rst <= 1'b1;
                  if (r_retry_cnt != '1) r_retry_cnt <= r_retry_cnt + CNT_W'(1);
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            StStable: begin
               if (!w_locked_s) begin
                  r_state <= StWaitLock;
                  r_timer <= '0;
               end else if (r_timer == STABLE_LAST) begin
                  r_state   <= StRun;
                  r_timer   <= '0;
                  r_sys_rst <= 1'b0;
                  r_ready   <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            StRun: begin
               if (!w_locked_s) begin
                  r_state   <= StWaitLock;
                  r_timer   <= '0;
                  r_sys_rst <= 1'b1;
                  r_ready   <= 1'b0;
                  if (r_lock_loss_cnt != '1) r_lock_loss_cnt <= r_lock_loss_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign o_pll_rst       = r_pll_rst;
   assign o_sys_rst       = r_sys_rst;
   assign o_ready         = r_ready;
   assign o_state         = r_state;
   assign o_lock_loss_cnt = r_lock_loss_cnt;
   assign o_retry_cnt     = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Vector-table bench for pll_lock_supervisor with a small expected-result queue.
module tb_pll_lock_supervisor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       pll_rst, sys_rst, ready;
   logic [1:0] state, loss_cnt, retry_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .SYNC_STAGES    (2),
      .STABLE_CYCLES  (8),
      .TIMEOUT_CYCLES (32),
      .PLLRST_CYCLES  (4),
      .CNT_W          (2)
   ) dut (
      .i_clock         (clk),
      .i_reset         (rst),
      .i_pll_locked    (locked),
      .o_pll_rst       (pll_rst),
      .o_sys_rst       (sys_rst),
      .o_ready         (ready),
      .o_state         (state),
      .o_lock_loss_cnt (loss_cnt),
      .o_retry_cnt     (retry_cnt)
   );

   // exp = {pll_rst, sys_rst, ready, state[1:0], loss[1:0], retry[1:0]}
   typedef struct {
      string      name;
      bit         do_rst;
      logic       locked;
      int         adv;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(input string n, input bit r, input logic l, input int a,
                               input logic pr, input logic sr, input logic rd,
                               input logic [1:0] st, input logic [1:0] ll,
                               input logic [1:0] rc);
      vec_t v;
      v.name   = n;
      v.do_rst = r;
      v.locked = l;
      v.adv    = a;
      v.exp    = {pr, sr, rd, st, ll, rc};
      return v;
   endfunction

   // Leaves the bench at the releasing negedge: that point is cycle 0.
   task automatic do_reset(input logic l);
      @(negedge clk);
      rst    = 1'b1;
      locked = l;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_pop();
      vec_t       e;
      logic [8:0] act;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got nothing, want an entry");
         return;
      end
      e   = sb.pop_front();
      act = {pll_rst, sys_rst, ready, state, loss_cnt, retry_cnt};
      if (act !== e.exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (pll_rst sys_rst ready state loss retry)",
                  e.name, act, e.exp);
      end
   endtask

   task automatic apply(input vec_t v);
      if (v.do_rst) do_reset(v.locked);
      locked = v.locked;
      sb.push_back(v);
      repeat (v.adv) @(negedge clk);
      check_pop();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Locked from reset: release after PLLRST + sync + 8-cycle window.
      vecs.push_back(mk("t1_c0",  1, 1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0));
      vecs.push_back(mk("t1_c3",  0, 1, 3, 1, 1, 0, 2'd0, 2'd0, 2'd0));
      vecs.push_back(mk("t1_c4",  0, 1, 1, 0, 1, 0, 2'd1, 2'd0, 2'd0));
      vecs.push_back(mk("t1_c5",  0, 1, 1, 0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("t1_c12", 0, 1, 7, 0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("t1_c13", 0, 1, 1, 0, 0, 1, 2'd3, 2'd0, 2'd0));
      // Lock loss in RUN and relock latency.
      vecs.push_back(mk("t4_drop2", 0, 0, 2,  0, 0, 1, 2'd3, 2'd0, 2'd0));
      vecs.push_back(mk("t4_drop3", 0, 0, 1,  0, 1, 0, 2'd1, 2'd1, 2'd0));
      vecs.push_back(mk("t4_rl10",  0, 1, 10, 0, 1, 0, 2'd2, 2'd1, 2'd0));
      vecs.push_back(mk("t4_rl11",  0, 1, 1,  0, 0, 1, 2'd3, 2'd1, 2'd0));
      // Further losses: counter saturates at 3.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ll;
         ll = (i + 2 > 3) ? 2'd3 : 2'(i + 2);
         vecs.push_back(mk("t5_drop",  0, 0, 3,  0, 1, 0, 2'd1, ll, 2'd0));
         vecs.push_back(mk("t5_relock", 0, 1, 11, 0, 0, 1, 2'd3, ll, 2'd0));
      end
      // Never locks: 4-wide pll_rst every 36 cycles, retry saturates.
      vecs.push_back(mk("t2_c3",  1, 0, 3,  1, 1, 0, 2'd0, 2'd0, 2'd0));
      vecs.push_back(mk("t2_c4",  0, 0, 1,  0, 1, 0, 2'd1, 2'd0, 2'd0));
      vecs.push_back(mk("t2_c35", 0, 0, 31, 0, 1, 0, 2'd1, 2'd0, 2'd0));
      vecs.push_back(mk("t2_c36", 0, 0, 1,  1, 1, 0, 2'd0, 2'd0, 2'd1));
      vecs.push_back(mk("t2_c39", 0, 0, 3,  1, 1, 0, 2'd0, 2'd0, 2'd1));
      vecs.push_back(mk("t2_c40", 0, 0, 1,  0, 1, 0, 2'd1, 2'd0, 2'd1));
      for (int i = 1; i < 4; i++) begin
         logic [1:0] rc;
         rc = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
         vecs.push_back(mk("t2_wait",  0, 0, 31, 0, 1, 0, 2'd1, 2'd0, 2'(i)));
         vecs.push_back(mk("t2_retry", 0, 0, 1,  1, 1, 0, 2'd0, 2'd0, rc));
         vecs.push_back(mk("t2_back",  0, 0, 4,  0, 1, 0, 2'd1, 2'd0, rc));
      end
      // One-cycle glitch at STABLE timer=5 restarts the full window.
      vecs.push_back(mk("t3_c8",  1, 1, 8, 0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("t3_c9",  0, 0, 1, 0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("t3_c11", 0, 1, 2, 0, 1, 0, 2'd1, 2'd0, 2'd0));
      vecs.push_back(mk("t3_c12", 0, 1, 1, 0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("t3_c19", 0, 1, 7, 0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("t3_c20", 0, 1, 1, 0, 0, 1, 2'd3, 2'd0, 2'd0));
      // Lock arriving on the timeout cycle wins.
      vecs.push_back(mk("tl_c33", 1, 0, 33, 0, 1, 0, 2'd1, 2'd0, 2'd0));
      vecs.push_back(mk("tl_c35", 0, 1, 2,  0, 1, 0, 2'd1, 2'd0, 2'd0));
      vecs.push_back(mk("tl_c36", 0, 1, 1,  0, 1, 0, 2'd2, 2'd0, 2'd0));
      // Lock lost on the final STABLE cycle stays out of RUN.
      vecs.push_back(mk("fs_c10", 1, 1, 10, 0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("fs_c11", 0, 0, 1,  0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("fs_c12", 0, 1, 1,  0, 1, 0, 2'd2, 2'd0, 2'd0));
      vecs.push_back(mk("fs_c13", 0, 1, 1,  0, 1, 0, 2'd1, 2'd0, 2'd0));

      foreach (vecs[i]) apply(vecs[i]);

      // Async reset mid-STABLE with a non-zero counter, checked without a clock edge.
      apply(mk("t6_run",  1, 1, 13, 0, 0, 1, 2'd3, 2'd0, 2'd0));
      apply(mk("t6_loss", 0, 0, 3,  0, 1, 0, 2'd1, 2'd1, 2'd0));
      apply(mk("t6_stab", 0, 1, 4,  0, 1, 0, 2'd2, 2'd1, 2'd0));
      #2 rst = 1'b1;
      #1 apply(mk("t6_async", 0, 1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0));
      @(negedge clk);
      rst = 1'b0;
      apply(mk("t6_c0",  0, 1, 0,  1, 1, 0, 2'd0, 2'd0, 2'd0));
      apply(mk("t6_c4",  0, 1, 4,  0, 1, 0, 2'd1, 2'd0, 2'd0));
      apply(mk("t6_c12", 0, 1, 8,  0, 1, 0, 2'd2, 2'd0, 2'd0));
      apply(mk("t6_c13", 0, 1, 1,  0, 0, 1, 2'd3, 2'd0, 2'd0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
